// File: rtl/uart_word_packer.sv
// uart_word_packer: packs UART RX bytes into DATA_WIDTH words, flushes partial
// words after an idle timeout, and buffers them in a first-word-fall-through
// FIFO that drains through a valid/ready handshake.
module uart_word_packer #(
    parameter int DATA_WIDTH      = 32,
    parameter int FIFO_DEPTH_LOG2 = 5,
    parameter int TIMEOUT_CYCLES  = 1000,
    parameter int MSB_FIRST       = 0
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      i_rx_dv,
    input  logic [7:0]                i_rx_byte,
    output logic                      o_word_valid,
    input  logic                      i_word_ready,
    output logic [DATA_WIDTH-1:0]     o_word,
    output logic [DATA_WIDTH/8-1:0]   o_word_strb,
    output logic                      o_full,
    output logic                      o_empty,
    output logic [FIFO_DEPTH_LOG2:0]  o_count,
    output logic                      o_overflow,
    input  logic                      i_clear_ovf
);

    localparam int BYTES = DATA_WIDTH / 8;
    localparam int CW    = $clog2(BYTES);
    localparam int DEPTH = 1 << FIFO_DEPTH_LOG2;
    localparam int TW    = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES);
    localparam bit TIMEOUT_EN = (TIMEOUT_CYCLES != 0);
    localparam logic [TW-1:0] TIMER_LAST = TIMEOUT_EN ? TW'(TIMEOUT_CYCLES - 1) : '0;
    localparam logic [CW-1:0] LAST_LANE  = CW'(BYTES - 1);
    localparam logic [FIFO_DEPTH_LOG2:0] DEPTH_CNT = {1'b1, {FIFO_DEPTH_LOG2{1'b0}}};

    // Packer state
    logic [CW-1:0]          byte_cnt_q, byte_cnt_d;
    logic [DATA_WIDTH-1:0]  lanes_q, lanes_d;
    logic [BYTES-1:0]       strb_q, strb_d;
    logic [TW-1:0]          timer_q, timer_d;
    logic                   push_q, push_d;
    logic [DATA_WIDTH-1:0]  push_data_q, push_data_d;
    logic [BYTES-1:0]       push_strb_q, push_strb_d;

    // Packer scratch
    logic [CW-1:0]          lane;
    logic [CW+2:0]          lane_base;
    logic [DATA_WIDTH-1:0]  lanes_new;
    logic [BYTES-1:0]       strb_new;

    // FIFO state
    logic [DATA_WIDTH+BYTES-1:0] fifo_mem [DEPTH];
    logic [FIFO_DEPTH_LOG2:0]    wr_ptr_q, wr_ptr_d;
    logic [FIFO_DEPTH_LOG2:0]    rd_ptr_q, rd_ptr_d;
    logic                        ovf_q, ovf_d;

    // FIFO scratch
    logic [FIFO_DEPTH_LOG2:0]    count;
    logic                        fifo_full;
    logic                        fifo_empty;
    logic                        pop;
    logic                        wr_en;
    logic                        drop;
    logic [DATA_WIDTH+BYTES-1:0] head;

    // Byte placement, full-word completion and idle-timeout flush; an incoming byte always beats a timeout
    always_comb begin
        byte_cnt_d  = byte_cnt_q;
        lanes_d     = lanes_q;
        strb_d      = strb_q;
        timer_d     = timer_q;
        push_d      = 1'b0;
        push_data_d = push_data_q;
        push_strb_d = push_strb_q;

        lane      = (MSB_FIRST != 0) ? (LAST_LANE - byte_cnt_q) : byte_cnt_q;
        lane_base = {lane, 3'b000};
        lanes_new = lanes_q;
        lanes_new[lane_base +: 8] = i_rx_byte;
        strb_new  = strb_q | (BYTES'(1) << lane);

        if (i_rx_dv) begin
            timer_d = '0;
            if (byte_cnt_q == LAST_LANE) begin
                push_d      = 1'b1;
                push_data_d = lanes_new;
                push_strb_d = '1;
                byte_cnt_d  = '0;
                lanes_d     = '0;
                strb_d      = '0;
            end else begin
                byte_cnt_d = byte_cnt_q + 1'b1;
                lanes_d    = lanes_new;
                strb_d     = strb_new;
            end
        end else if (TIMEOUT_EN && (byte_cnt_q != '0)) begin
            if (timer_q == TIMER_LAST) begin
                push_d      = 1'b1;
                push_data_d = lanes_q;
                push_strb_d = strb_q;
                byte_cnt_d  = '0;
                lanes_d     = '0;
                strb_d      = '0;
                timer_d     = '0;
            end else begin
                timer_d = timer_q + 1'b1;
            end
        end
    end

    // FIFO bookkeeping: a push into a full FIFO survives only if the head leaves in the same cycle
    always_comb begin
        count      = wr_ptr_q - rd_ptr_q;
        fifo_full  = (count == DEPTH_CNT);
        fifo_empty = (count == '0);
        pop        = !fifo_empty && i_word_ready;
        wr_en      = push_q && (!fifo_full || pop);
        drop       = push_q && fifo_full && !pop;

        wr_ptr_d = wr_en ? (wr_ptr_q + 1'b1) : wr_ptr_q;
        rd_ptr_d = pop   ? (rd_ptr_q + 1'b1) : rd_ptr_q;

        if (drop) begin
            ovf_d = 1'b1;
        end else if (i_clear_ovf) begin
            ovf_d = 1'b0;
        end else begin
            ovf_d = ovf_q;
        end
    end

    // Packer and FIFO control registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            byte_cnt_q  <= '0;
            lanes_q     <= '0;
            strb_q      <= '0;
            timer_q     <= '0;
            push_q      <= 1'b0;
            push_data_q <= '0;
            push_strb_q <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            ovf_q       <= 1'b0;
        end else begin
            byte_cnt_q  <= byte_cnt_d;
            lanes_q     <= lanes_d;
            strb_q      <= strb_d;
            timer_q     <= timer_d;
            push_q      <= push_d;
            push_data_q <= push_data_d;
            push_strb_q <= push_strb_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            ovf_q       <= ovf_d;
        end
    end

    // Word storage; contents need no reset because the outputs are masked while empty
    always_ff @(posedge clk) begin
        if (wr_en) begin
            fifo_mem[wr_ptr_q[FIFO_DEPTH_LOG2-1:0]] <= {push_strb_q, push_data_q};
        end
    end

    assign head         = fifo_mem[rd_ptr_q[FIFO_DEPTH_LOG2-1:0]];
    assign o_word_valid = !fifo_empty;
    assign o_word       = fifo_empty ? '0 : head[DATA_WIDTH-1:0];
    assign o_word_strb  = fifo_empty ? '0 : head[DATA_WIDTH+BYTES-1:DATA_WIDTH];
    assign o_full       = fifo_full;
    assign o_empty      = fifo_empty;
    assign o_count      = count;
    assign o_overflow   = ovf_q;

endmodule

// File: doc/uart_word_packer.md
Name: uart_word_packer

Overview:
- Parametrised successor to the fixed 8-to-32 RX packer and FIFO pair in the UART-to-APB path.
- Collects bytes from a UART RX byte interface and packs them into DATA_WIDTH words, with a configurable byte order.
- Flushes partial words after an idle timeout and tags them with per-lane byte strobes.
- Buffers words in an internal first-word-fall-through FIFO that drains through a valid/ready handshake toward the APB master side.

Parameters:
- DATA_WIDTH, 32: output word width; a multiple of 8, range 16..64. BYTES = DATA_WIDTH/8.
- FIFO_DEPTH_LOG2, 5: FIFO holds 2**FIFO_DEPTH_LOG2 words.
- TIMEOUT_CYCLES, 1000: idle clk cycles after the last byte before a partial word is flushed. 0 disables the timeout.
- MSB_FIRST, 0: 0 places the first byte in lane 0 (bits 7:0). 1 places the first byte in lane BYTES-1.

Ports:
- clk  in  1  single clock for all logic.
- reset  in  1  asynchronous, active-high reset.
- i_rx_dv  in  1  one-cycle strobe: i_rx_byte is valid.
- i_rx_byte  in  8  received byte.
- o_word_valid  out  1  FIFO head word available.
- i_word_ready  in  1  consumer accepts the head word when o_word_valid=1.
- o_word  out  DATA_WIDTH  FIFO head data.
- o_word_strb  out  BYTES  lanes holding received bytes in the head word.
- o_full  out  1  FIFO full.
- o_empty  out  1  FIFO empty.
- o_count  out  FIFO_DEPTH_LOG2+1  number of words in the FIFO.
- o_overflow  out  1  sticky: a word was dropped.
- i_clear_ovf  in  1  clears o_overflow.

Behaviour:
- Reset (asynchronous): all outputs go to 0 except o_empty=1. Clears the byte count, lane register, timer, pending push and FIFO pointers.
- Assertion mid-word discards the partial word; no flush occurs.
- Packer: byte_cnt runs 0..BYTES-1.
  - On i_rx_dv, the byte is written to lane byte_cnt (MSB_FIRST=0) or lane BYTES-1-byte_cnt (MSB_FIRST=1), and its strobe bit is set.
  - Unfilled lanes read 0.
- Full-word push: when the dv delivers byte BYTES-1, a push is registered next cycle with strb all ones. byte_cnt returns to 0 and the lanes/strobes clear in the same cycle.
- Timer:
  - Cleared on every dv.
  - Counts while byte_cnt>0 and no dv.
  - When it reaches TIMEOUT_CYCLES, a push is registered next cycle with the partial strobes, and the packer clears.
  - Never runs when byte_cnt=0.
- Timeout vs. dv in the same cycle: dv wins. The byte is appended, the timer restarts, and a full-word push occurs only if that byte completes the word.
- Latency: last-byte dv at cycle N -> FIFO write at N+1 -> o_word_valid=1 at N+2 when the FIFO was empty. Timeout flush has the same +2 latency from the timeout-match cycle.
- FIFO:
  - First-word-fall-through; the head is registered and held stable while o_word_valid=1 and i_word_ready=0.
  - Pop occurs when o_word_valid & i_word_ready.
  - Pointers wrap modulo depth; an extra pointer bit distinguishes full from empty.
  - o_count is exact, 0..2**FIFO_DEPTH_LOG2.
- Push while full:
  - Accepted if a pop occurs in the same cycle; count is unchanged.
  - Otherwise the word is dropped, o_overflow=1 and count is unchanged.
  - The packer is never stalled; RX bytes are never back-pressured.
- Push and pop on an empty FIFO: the push lands and appears at the head next cycle; the pop is ignored because valid was 0.
- o_overflow: set has priority over i_clear_ovf in the same cycle. Otherwise i_clear_ovf clears it next cycle.
- o_full = (count == depth); o_empty = (count == 0). Both are registered-consistent with o_count.

Test Plan:
- DATA_WIDTH=32, MSB_FIRST=0: bytes 11,22,33,44 with ready=1 -> o_word=32'h44332211, strb=4'hF, valid 2 cycles after the 4th dv, one cycle wide.
- MSB_FIRST=1, same bytes -> o_word=32'h11223344, strb=4'hF.
- TIMEOUT_CYCLES=16: bytes AA,BB then idle -> a push 17 cycles after the last dv gives o_word=32'h0000BBAA, strb=4'h3. A third byte arriving on the timeout-match cycle suppresses the flush.
- FIFO_DEPTH_LOG2=2, ready=0: push 5 full words -> o_count=4, o_full=1, 5th dropped, o_overflow=1. Pulse i_clear_ovf -> 0.
- When full, 5th push coincides with a pop (ready=1 for one cycle) -> no overflow, count stays 4. Drain order matches input order, and the head holds stable while ready=0.
- Assert reset after 2 bytes, release, send 4 bytes -> only the new 4-byte word appears; the first 2 bytes are never seen.
